// File: rtl/rfft_pkg.sv
// rtl/rfft_pkg.sv - shared constants, FSM states, sample struct and bit-reverse helper for the rfft unload path
package rfft_pkg;

    localparam int ADDR_BIT   = 6;
    localparam int DATA_BIT   = 16;
    localparam int N          = 256;
    localparam int n          = 8;
    localparam int MEM_HEIGHT = N / 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DATA_BIT-1:0] r;
        logic [DATA_BIT-1:0] i;
        logic [n-1:0]        idx;
        logic                last;
    } sample_t;

    function automatic logic [n-1:0] bitrev(input logic [n-1:0] x);
        logic [n-1:0] y;
        for (int j = 0; j < n; j++) begin
            y[j] = x[n-1-j];
        end
        return y;
    endfunction

endpackage

// File: rtl/rfft_skid_fifo.sv
// rtl/rfft_skid_fifo.sv - 2-entry sample FIFO with occupancy count and synchronous flush
module rfft_skid_fifo
    import rfft_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  sample_t    data_i,
    input  logic       pop_i,
    output sample_t    data_o,
    output logic [1:0] count_o
);

    sample_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Empty head reads as zero so the stream outputs are 0 whenever nothing is valid.
    assign data_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/rfft_result_reader.sv
// rtl/rfft_result_reader.sv - reads rfft_4pt banks in frequency order and streams samples out
// RFFT_BITREV_EN defined: bit-reversed fetch (natural order); undefined: raw storage order.
module rfft_result_reader
    import rfft_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  re,
    output logic [ADDR_BIT*4-1:0] addr_read,
    input  logic [DATA_BIT-1:0]   mem0,
    input  logic [DATA_BIT-1:0]   mem1,
    input  logic [DATA_BIT-1:0]   mem2,
    input  logic [DATA_BIT-1:0]   mem3,
    input  logic [DATA_BIT-1:0]   mem0_i,
    input  logic [DATA_BIT-1:0]   mem1_i,
    input  logic [DATA_BIT-1:0]   mem2_i,
    input  logic [DATA_BIT-1:0]   mem3_i,
    output logic [DATA_BIT-1:0]   out_r,
    output logic [DATA_BIT-1:0]   out_i,
    output logic [n-1:0]          out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [n-1:0] K_LAST = n'(N - 1);

    state_e       state_q, state_d;
    logic [n-1:0] k_issue_q, k_issue_d;
    logic [n-1:0] k_rd_q;
    logic [1:0]   bank_q;
    logic         inflight_q;
    logic [n-1:0] r;
    logic         issue;
    logic         pop;
    logic [1:0]   fifo_count;
    sample_t      push_data;
    sample_t      head;

`ifdef RFFT_BITREV_EN
    assign r = bitrev(k_issue_q);
`else
    assign r = k_issue_q;
`endif

    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        k_issue_d = k_issue_q;
        issue     = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    k_issue_d = '0;
                end
            end
            ISSUE: begin
                // Credit counts buffered plus in-flight samples, freeing a slot on this cycle's pop.
                issue = (3'(fifo_count) + 3'(inflight_q) - 3'(pop)) < 3'd2;
                if (issue) begin
                    if (k_issue_q == K_LAST) begin
                        state_d = DRAIN;
                    end else begin
                        k_issue_d = k_issue_q + n'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifo_count == 2'd0 && !inflight_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_issue_q  <= '0;
            k_rd_q     <= '0;
            bank_q     <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_issue_q  <= k_issue_d;
            inflight_q <= issue;
            if (issue) begin
                bank_q <= r[n-1:n-2];
                k_rd_q <= k_issue_q;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign re        = issue;
    assign addr_read = issue ? {4{r[ADDR_BIT-1:0]}} : '0;

    always_comb begin
        push_data      = '0;
        push_data.idx  = k_rd_q;
        push_data.last = (k_rd_q == K_LAST);
        case (bank_q)
            2'd0:    begin push_data.r = mem0; push_data.i = mem0_i; end
            2'd1:    begin push_data.r = mem1; push_data.i = mem1_i; end
            2'd2:    begin push_data.r = mem2; push_data.i = mem2_i; end
            default: begin push_data.r = mem3; push_data.i = mem3_i; end
        endcase
    end

    rfft_skid_fifo u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count)
    );

    assign out_r    = head.r;
    assign out_i    = head.i;
    assign out_idx  = head.idx;
    assign out_last = head.last;

endmodule

// File: tb/tb_rfft_result_reader.sv
// tb/tb_rfft_result_reader.sv - scoreboard bench for rfft_result_reader against a bank memory model
module tb_rfft_result_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, re;
    logic [23:0] addr_read;
    logic [15:0] mem0, mem1, mem2, mem3, mem0_i, mem1_i, mem2_i, mem3_i;
    logic [15:0] out_r, out_i;
    logic [7:0]  out_idx;
    logic        out_valid, out_last;
    logic        out_ready = 1'b1;

    rfft_result_reader dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .re(re), .addr_read(addr_read),
        .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3),
        .mem0_i(mem0_i), .mem1_i(mem1_i), .mem2_i(mem2_i), .mem3_i(mem3_i),
        .out_r(out_r), .out_i(out_i), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int mode = 0;
    int start_cyc, first_valid_cyc, done_cnt, done_cyc, hs_cnt, re_cnt;
    int max_out, stall_re, last_hs_cyc;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_out;
    logic [40:0] sb[$];
    logic [40:0] exp_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] exp_sample(input int k);
        logic [7:0]  kk, rv;
        logic [15:0] v;
        kk = 8'(k);
`ifdef RFFT_BITREV_EN
        for (int j = 0; j < 8; j++) rv[j] = kk[7-j];
`else
        rv = kk;
`endif
        v = {8'h00, rv};
        return {v, 16'd0 - v, kk, (k == 255)};
    endfunction

    // Bank b, address a holds 64*b+a (real) and its negation (imag), one cycle after re.
    logic [15:0] mr[4] = '{default: 16'd0};
    logic [15:0] mi[4] = '{default: 16'd0};
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re) begin
            for (int b = 0; b < 4; b++) begin
                mr[b] <= 16'(64 * b) + {10'd0, addr_read[b*6 +: 6]};
                mi[b] <= 16'd0 - (16'(64 * b) + {10'd0, addr_read[b*6 +: 6]});
            end
        end
    end
    assign mem0 = mr[0]; assign mem1 = mr[1]; assign mem2 = mr[2]; assign mem3 = mr[3];
    assign mem0_i = mi[0]; assign mem1_i = mi[1]; assign mem2_i = mi[2]; assign mem3_i = mi[3];

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2:       out_ready = (first_valid_cyc >= 0) && (cyc >= first_valid_cyc + 20);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (re) re_cnt++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall)
                chk("hold", {23'd0, out_valid, out_r, out_i, out_idx, out_last}, prev_out);
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (out_last) last_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_sample", {23'd0, out_r, out_i, out_idx, out_last}, 64'd0);
                end else begin
                    exp_s = sb.pop_front();
                    chk("sample", {23'd0, out_r, out_i, out_idx, out_last}, {23'd0, exp_s});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {23'd0, out_valid, out_r, out_i, out_idx, out_last};
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (re_cnt - hs_cnt > max_out) max_out = re_cnt - hs_cnt;
            if (mode == 2 && first_valid_cyc >= 0 && cyc == first_valid_cyc + 19) stall_re = re_cnt;
        end
    end

    task automatic clear_stats(input int md);
        mode = md;
        first_valid_cyc = -1; done_cnt = 0; done_cyc = -1; hs_cnt = 0; re_cnt = 0;
        max_out = 0; stall_re = 0; last_hs_cyc = -1;
    endtask

    task automatic kick();
        @(posedge clk); #1;
        for (int k = 0; k < 256; k++) sb.push_back(exp_sample(k));
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_unload(input int md, input bit spurious);
        bit timeout;
        clear_stats(md);
        kick();
        timeout = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (done_cnt != 0) begin
                timeout = 1'b0;
                break;
            end
            start = spurious && (cyc == start_cyc + 100);
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (timeout) chk("done_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("done_count", done_cnt, 1);
        chk("handshakes", hs_cnt, 256);
        chk("sb_left", sb.size(), 0);
        chk("max_buffered_le2", max_out <= 2, 1);
        chk("busy_after", busy, 0);
        if (md == 0) begin
            chk("first_valid_lat", first_valid_cyc - start_cyc, 3);
            chk("last_hs_lat", last_hs_cyc - start_cyc, 258);
            chk("done_lat", done_cyc - start_cyc, 259);
        end
        if (md == 2) chk("stall_reads_le2", stall_re <= 2, 1);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {busy, done, re, out_valid, out_last}, 5'd0);
        chk("rst_data", {addr_read, out_r, out_i, out_idx}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_unload(0, 1'b0);
        run_unload(1, 1'b0);
        run_unload(0, 1'b1);

        clear_stats(0);
        kick();
        for (int t = 0; t < 100 && cyc < start_cyc + 50; t++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {busy, done, re, out_valid, out_last}, 5'd0);
        chk("midrst_data", {addr_read, out_r, out_i, out_idx}, 64'd0);
        sb.delete();
        hs_cnt = 0;
        repeat (300) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_no_output", hs_cnt, 0);

        run_unload(0, 1'b0);
        run_unload(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rfft_result_reader.md
# rfft_result_reader

Unload engine for the 4-bank radix-4 real-FFT datapath `rfft_4pt`. After the last butterfly stage completes, it reads the N complex results out of the four memory banks (MEM_HEIGHT words each) through the shared read-address port. It reorders them into natural frequency order and streams them out over a valid/ready interface. It is the read-side counterpart of the load/sequencing logic that writes samples and drives stages into `rfft_4pt`.

## Interface
Parameters:
- `ADDR_BIT`, 6, per-bank address width
- `DATA_BIT`, 16, real and imaginary word width
- `N`, 256, transform length, power of 4
- `n`, 8, log2(N)
- `MEM_HEIGHT`, N/4, words per bank

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that begins an unload; ignored unless idle
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse after the last output handshake
- `re`  out  1  bank read enable
- `addr_read`  out  ADDR_BIT*4  four address fields; all four carry the same address
- `mem0`..`mem3`  in  DATA_BIT each  bank real read data, valid 1 cycle after `re`
- `mem0_i`..`mem3_i`  in  DATA_BIT each  bank imaginary read data, same timing
- `out_r`, `out_i`  out  DATA_BIT each  result sample
- `out_idx`  out  n  frequency index k of the current sample
- `out_valid`  out  1  sample present
- `out_ready`  in  1  sink accepts; a transfer occurs when valid and ready are both high
- `out_last`  out  1  high with k = N-1

## Operation
- Reset: every output is 0. The FSM goes to IDLE, the skid FIFO is emptied, and in-flight reads are discarded.
- FSM states:
  - IDLE: on `start`, go to ISSUE and clear k_issue to 0.
  - ISSUE: issue one read per cycle while credit allows. After the read for k_issue = N-1 is issued, go to DRAIN.
  - DRAIN: wait until the FIFO is empty, no read is in flight, and the last handshake has occurred. Then pulse `done` and return to IDLE.
- Location of result k: r = bitrev_n(k); bank = r[n-1:n-2]; addr = r[n-3:0].
- Read issue: `re` is high and `addr_read` holds addr in every field. The bank select is registered along with the read. One cycle later, the selected bank's `memX` and `memX_i` plus k are written into the FIFO.
- Credit rule: a read is issued when fifo_count + inflight − pop < 2, where pop means an output handshake this cycle. This sustains 1 sample per cycle while `out_ready` stays high and never overflows.
- Address width: addr is exactly ADDR_BIT = n−2 bits. k_issue wraps only at the IDLE transition and never silently.
- `start` while busy: ignored, with no effect on the counters.
- `out_*` hold stable while `out_valid && !out_ready`. Data is never dropped or duplicated.

## Timing
- `start` high in cycle 0 → `busy` and the first `re` in cycle 1 → data in cycle 2 → first `out_valid` in cycle 3.
- With `out_ready` held high: one sample per cycle. The last handshake (k = N−1) is in cycle N+2, and `done` is in cycle N+3.
- Backpressure: `re` stalls within 1 cycle. At most 2 samples are buffered.
- `rst` asserted mid-unload: on the next cycle all outputs are 0 and `done` does not pulse.

## Configuration
- `RFFT_BITREV_EN` defined: the reordering applies r = bitrev_n(k), giving natural-order output. This is the normal build.
- Not defined: r = k, giving raw storage order with bank = k[n-1:n-2] and addr = k[n-3:0]. `out_idx` still counts 0..N−1. This build is used for datapath debug.

## Structure
- Shared package `rfft_pkg`:
  - the ADDR_BIT, DATA_BIT, N, and n constants
  - the FSM state enum {IDLE, ISSUE, DRAIN}
  - the bitrev function
  - a sample struct {r, i, idx, last}
- Sub-module `rfft_skid_fifo`: a 2-entry FIFO of the sample struct with count output, push/pop, and synchronous flush on `rst`.

## Test plan
1. Memory model holds bank b, addr a real = 64b+a and imag = −(64b+a); `RFFT_BITREV_EN`; `out_ready`=1 → k=0 gives 0, k=1 gives 128 (bank 2, addr 0), k=2 gives 64, k=255 gives 255. `out_last` is high only with k=255, and `done` pulses in cycle 259.
2. Same data with `out_ready` random at 50% → the same 256-sample sequence with no gaps or duplicates, `out_*` stable under stall, and `re` never causes FIFO overflow.
3. `start` pulsed again at cycle 100 → ignored, and exactly 256 samples are produced.
4. `rst` at cycle 50 → the next cycle has all outputs 0 and no `done`. A new `start` then restarts from k=0.
5. Build without the macro → the k-th output equals k (real) and −k (imag).
6. `out_ready` held low for 20 cycles after the first valid → at most 2 reads are issued, and output resumes with k=0, 1, 2 in order.
